// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, wrapping h/v position counters and
// registered sync/blanking/frame-start outputs decoded from the next counter values.
module vga_sync_gen #(
  parameter logic [9:0] H_VISIBLE = 10'd640,
  parameter logic [9:0] H_FP      = 10'd16,
  parameter logic [9:0] H_SYNC    = 10'd96,
  parameter logic [9:0] H_BP      = 10'd48,
  parameter logic [9:0] V_VISIBLE = 10'd480,
  parameter logic [9:0] V_FP      = 10'd10,
  parameter logic [9:0] V_SYNC    = 10'd2,
  parameter logic [9:0] V_BP      = 10'd33,
  parameter int         CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = int'(H_VISIBLE) + int'(H_FP) + int'(H_SYNC) + int'(H_BP);
  localparam int V_TOTAL = int'(V_VISIBLE) + int'(V_FP) + int'(V_SYNC) + int'(V_BP);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(int'(H_VISIBLE) + int'(H_FP));
  localparam logic [9:0] HS_END   = 10'(int'(H_VISIBLE) + int'(H_FP) + int'(H_SYNC));
  localparam logic [9:0] VS_START = 10'(int'(V_VISIBLE) + int'(V_FP));
  localparam logic [9:0] VS_END   = 10'(int'(V_VISIBLE) + int'(V_FP) + int'(V_SYNC));
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       tick;
  logic       line_end;

  always_comb begin
    // With CLK_DIV = 1 DIV_LAST is 0 and div never leaves 0, so tick stays high.
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? 4'd0 : div_q + 4'd1;
    line_end = tick && (hcnt_q == H_LAST);

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      hcnt_d = line_end ? 10'd0 : hcnt_q + 10'd1;
    end
    if (line_end) begin
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end

    // Decode from the next counters so the registered outputs line up with them.
    hsync_d       = !((hcnt_d >= HS_START) && (hcnt_d < HS_END));
    vsync_d       = !((vcnt_d >= VS_START) && (vcnt_d < VS_END));
    video_on_d    = (hcnt_d < H_VISIBLE) && (vcnt_d < V_VISIBLE);
    frame_start_d = line_end && (vcnt_q == V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= 4'd0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_tick    = tick;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing for divider/line, a reduced
// 25x15 timing for frame, blanking and mid-frame reset, and a CLK_DIV = 1 copy.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] d_hcnt, d_vcnt;
  logic       d_hsync, d_vsync, d_von, d_tick, d_frame;
  logic [9:0] s_hcnt, s_vcnt;
  logic       s_hsync, s_vsync, s_von, s_tick, s_frame;
  logic [9:0] o_hcnt, o_vcnt;
  logic       o_hsync, o_vsync, o_von, o_tick, o_frame;

  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_n), .hcnt(d_hcnt), .vcnt(d_vcnt), .hsync(d_hsync),
    .vsync(d_vsync), .video_on(d_von), .pix_tick(d_tick), .frame_start(d_frame)
  );

  // Reduced timing: H 16+2+4+3 = 25, V 8+2+2+3 = 15; hsync low 18..21, vsync low 10..11.
  vga_sync_gen #(
    .H_VISIBLE(10'd16), .H_FP(10'd2), .H_SYNC(10'd4), .H_BP(10'd3),
    .V_VISIBLE(10'd8), .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd3), .CLK_DIV(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .hcnt(s_hcnt), .vcnt(s_vcnt), .hsync(s_hsync),
    .vsync(s_vsync), .video_on(s_von), .pix_tick(s_tick), .frame_start(s_frame)
  );

  vga_sync_gen #(
    .H_VISIBLE(10'd16), .H_FP(10'd2), .H_SYNC(10'd4), .H_BP(10'd3),
    .V_VISIBLE(10'd8), .V_FP(10'd2), .V_SYNC(10'd2), .V_BP(10'd3), .CLK_DIV(1)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .hcnt(o_hcnt), .vcnt(o_vcnt), .hsync(o_hsync),
    .vsync(o_vsync), .video_on(o_von), .pix_tick(o_tick), .frame_start(o_frame)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int lo_cnt, first_lo, guard, fs_cnt, fs_k, fs_h, fs_v, vs_lo, hs_lo;
    int vs_min, vs_max, hmax, vmax, seen, first_tick, prev_h, h_err, o_low;
    int o_fs_cnt, o_fs1, o_fs2, o_line1, o_line2, hs_early;
    bit done;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_hcnt", int'(d_hcnt), 0);
    check("rst_vcnt", int'(d_vcnt), 0);
    check("rst_hsync", int'(d_hsync), 1);
    check("rst_vsync", int'(d_vsync), 1);
    check("rst_video_on", int'(d_von), 0);
    check("rst_pix_tick", int'(d_tick), 0);
    check("rst_frame_start", int'(d_frame), 0);
    check("rst_pix_tick_div1", int'(o_tick), 1);

    // Divider: tick on cycles 2,4,..,10; hcnt = 5 after cycle 10
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("div_tick_c%0d", k), int'(d_tick), (k % 2 == 0) ? 1 : 0);
      if (k == 1) check("von_before_edge", int'(d_von), 0);
      if (k == 2) check("von_after_release", int'(d_von), 1);
      check($sformatf("no_fs_release_c%0d", k), int'(d_frame), 0);
      @(negedge clk);
      #1;
    end
    check("div_hcnt_after10", int'(d_hcnt), 5);

    // One full line at defaults
    lo_cnt = 0; first_lo = -1; done = 0; guard = 0;
    while (!done && guard < 2000) begin
      if (d_tick) begin
        if (!d_hsync) begin
          lo_cnt++;
          if (first_lo < 0) first_lo = int'(d_hcnt);
        end
        if (d_hcnt == 10'd799) begin
          check("line_v_before_wrap", int'(d_vcnt), 0);
          @(negedge clk);
          #1;
          check("line_wrap_hcnt", int'(d_hcnt), 0);
          check("line_wrap_vcnt", int'(d_vcnt), 1);
          done = 1;
        end
      end
      if (!done) begin
        @(negedge clk);
        #1;
        guard++;
      end
    end
    check("line_done", int'(done), 1);
    check("hsync_low_ticks", lo_cnt, 96);
    check("hsync_first_low_hcnt", first_lo, 656);

    // Frame on reduced timing: align to frame_start, then run one frame
    guard = 0;
    while (!s_frame && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("frame_align_found", int'(s_frame), 1);
    check("frame_align_hcnt", int'(s_hcnt), 0);
    check("frame_align_vcnt", int'(s_vcnt), 0);
    fs_cnt = 0; fs_k = -1; fs_h = -1; fs_v = -1; vs_lo = 0; hs_lo = 0;
    vs_min = 999; vs_max = -1; hmax = 0; vmax = 0; seen = 0;
    for (int k = 1; k <= 750; k++) begin
      @(negedge clk);
      #1;
      if (int'(s_hcnt) > hmax) hmax = int'(s_hcnt);
      if (int'(s_vcnt) > vmax) vmax = int'(s_vcnt);
      if (s_frame) begin
        fs_cnt++;
        fs_k = k; fs_h = int'(s_hcnt); fs_v = int'(s_vcnt);
      end
      if (s_tick) begin
        if (!s_hsync) hs_lo++;
        if (!s_vsync) begin
          vs_lo++;
          if (int'(s_vcnt) < vs_min) vs_min = int'(s_vcnt);
          if (int'(s_vcnt) > vs_max) vs_max = int'(s_vcnt);
        end
        if (s_hcnt == 10'd15 && s_vcnt == 10'd7) begin
          check("von_last_visible", int'(s_von), 1); seen++;
        end
        if (s_hcnt == 10'd16 && s_vcnt == 10'd0) begin
          check("von_h_blank", int'(s_von), 0); seen++;
        end
        if (s_hcnt == 10'd0 && s_vcnt == 10'd8) begin
          check("von_v_blank", int'(s_von), 0); seen++;
        end
        if (s_hcnt == 10'd24 && s_vcnt == 10'd14) begin
          check("von_last_pixel", int'(s_von), 0); seen++;
        end
      end
    end
    check("blank_points_seen", seen, 4);
    check("frame_fs_count", fs_cnt, 1);
    check("frame_fs_cycle", fs_k, 750);
    check("frame_fs_hcnt", fs_h, 0);
    check("frame_fs_vcnt", fs_v, 0);
    check("vsync_low_ticks", vs_lo, 50);
    check("vsync_low_min_vcnt", vs_min, 10);
    check("vsync_low_max_vcnt", vs_max, 11);
    check("hsync_low_ticks_frame", hs_lo, 60);
    check("hcnt_max", hmax, 24);
    check("vcnt_max", vmax, 14);

    // Mid-frame reset during hsync and vsync low
    guard = 0;
    while (!(s_hcnt == 10'd20 && s_vcnt == 10'd11) && guard < 1000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("midrst_pos_found", int'(s_hcnt == 10'd20 && s_vcnt == 10'd11), 1);
    check("midrst_pre_hsync", int'(s_hsync), 0);
    check("midrst_pre_vsync", int'(s_vsync), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_hcnt", int'(s_hcnt), 0);
    check("midrst_vcnt", int'(s_vcnt), 0);
    check("midrst_hsync", int'(s_hsync), 1);
    check("midrst_vsync", int'(s_vsync), 1);
    check("midrst_video_on", int'(s_von), 0);
    check("midrst_pix_tick", int'(s_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Restart on reduced timing plus CLK_DIV = 1 behaviour
    first_tick = -1; hs_early = 0; prev_h = 0; h_err = 0; o_low = 0;
    o_fs_cnt = 0; o_fs1 = -1; o_fs2 = -1; o_line1 = -1; o_line2 = -1;
    for (int k = 1; k <= 760; k++) begin
      #1;
      if (s_tick && first_tick < 0) first_tick = k;
      if (k <= 30 && !s_hsync) hs_early++;
      if (k == 51) begin
        check("restart_hcnt_k51", int'(s_hcnt), 0);
        check("restart_vcnt_k51", int'(s_vcnt), 1);
      end
      if (!o_tick) o_low++;
      if (k > 1 && int'(o_hcnt) != (prev_h + 1) % 25) h_err++;
      prev_h = int'(o_hcnt);
      if (o_hcnt == 10'd0 && k > 1) begin
        if (o_line1 < 0) o_line1 = k;
        else if (o_line2 < 0) o_line2 = k;
      end
      if (o_frame) begin
        o_fs_cnt++;
        if (o_fs1 < 0) o_fs1 = k;
        else if (o_fs2 < 0) o_fs2 = k;
      end
      @(negedge clk);
    end
    check("restart_first_tick", first_tick, 2);
    check("restart_no_partial_hsync", hs_early, 0);
    check("div1_tick_low_cycles", o_low, 0);
    check("div1_hcnt_step_errors", h_err, 0);
    check("div1_line_period", o_line2 - o_line1, 25);
    check("div1_fs_count", o_fs_cnt, 2);
    check("div1_fs_first", o_fs1, 376);
    check("div1_fs_period", o_fs2 - o_fs1, 375);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 10'd640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 10'd16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 10'd96, hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 10'd48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 10'd480, visible lines per frame.
REQ-006 The block SHALL have parameters V_FP = 10'd10, V_SYNC = 10'd2 and V_BP = 10'd33, the vertical porch and sync widths in lines.
REQ-007 The block SHALL have parameter CLK_DIV, default 2, the number of clk cycles per pixel (legal range 1..15).
REQ-008 The block SHALL have port clk, input, 1 bit: the single system clock (50 MHz nominal).
REQ-009 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-010 The block SHALL have port hcnt, output, 10 bits: horizontal pixel position, which feeds the quadrant selector.
REQ-011 The block SHALL have port vcnt, output, 10 bits: vertical line position, which feeds the quadrant selector.
REQ-012 The block SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-013 The block SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-014 The block SHALL have port video_on, output, 1 bit: high while the current pixel is visible.
REQ-015 The block SHALL have port pix_tick, output, 1 bit: a one-clk pulse marking the pixel rate.
REQ-016 The block SHALL have port frame_start, output, 1 bit: a one-clk pulse at the start of each frame.

Function
REQ-017 The pixel divider SHALL run a 4-bit counter div 0..CLK_DIV-1, wrap to 0, and assert pix_tick in every clk cycle where div == CLK_DIV-1.
REQ-018 With CLK_DIV = 1, pix_tick SHALL be held high continuously.
REQ-019 The line length SHALL be H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 at defaults), and the frame length SHALL be V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-020 hcnt SHALL change only on clk edges where pix_tick is high: it increments by 1, and wraps from H_TOTAL-1 to 0.
REQ-021 vcnt SHALL change only on a pix_tick edge where hcnt == H_TOTAL-1: it increments by 1, and wraps from V_TOTAL-1 to 0; both counters wrap on the same edge at (H_TOTAL-1, V_TOTAL-1).
REQ-022 hcnt SHALL never exceed H_TOTAL-1, and vcnt SHALL never exceed V_TOTAL-1.
REQ-023 hsync SHALL be 0 exactly when H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults), otherwise 1.
REQ-024 vsync SHALL be 0 exactly when V_VISIBLE+V_FP <= vcnt < V_VISIBLE+V_FP+V_SYNC (490..491 at defaults), otherwise 1.
REQ-025 video_on SHALL be 1 exactly when hcnt < H_VISIBLE and vcnt < V_VISIBLE.
REQ-026 hsync, vsync and video_on SHALL be registered outputs, decoded from the next counter values, so that they are cycle-aligned with the hcnt/vcnt values presented in the same cycle (zero relative latency, no combinational path from the counters to the outputs).
REQ-027 frame_start SHALL be registered and high for exactly one clk cycle: the first cycle in which (hcnt, vcnt) = (0, 0) after the wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-028 frame_start SHALL NOT assert on reset release.
REQ-029 frame_start SHALL NOT assert again during the remaining CLK_DIV-1 cycles of pixel (0, 0).

Reset
REQ-030 While rst_n = 0, the block SHALL asynchronously force div = 0, hcnt = 0, vcnt = 0, hsync = 1, vsync = 1, video_on = 0, frame_start = 0, with pix_tick = 0 unless CLK_DIV = 1.
REQ-031 On the first clk edge after rst_n rises, video_on SHALL become the decode of the current counters (1 at (0, 0)).
REQ-032 After reset release, the first pix_tick SHALL occur in the CLK_DIV-th clk cycle.
REQ-033 Reset asserted mid-frame (including during hsync or vsync low) SHALL immediately force the REQ-030 values; counting SHALL restart from (0, 0) with no partial sync pulse.

Verification
REQ-034 The bench SHALL cover divider: CLK_DIV = 2, release reset, run 10 clk -> pix_tick high on cycles 2, 4, 6, 8, 10; hcnt = 5 after cycle 10.
REQ-035 The bench SHALL cover the line: one full line at defaults -> hsync low for exactly 96 pixel ticks starting at hcnt = 656; hcnt wraps 799 -> 0 and vcnt goes 0 -> 1 on the same edge.
REQ-036 The bench SHALL cover the frame: run 800*525 pixel ticks -> vsync low only for vcnt = 490 and 491 (1600 ticks total); frame_start pulses exactly once, in the cycle (0, 0) reappears.
REQ-037 The bench SHALL cover blanking: sample at (639, 479) -> video_on = 1; at (640, 0), (0, 480) and (799, 524) -> video_on = 0, checked in the same cycle as the counters.
REQ-038 The bench SHALL cover mid-operation reset: assert rst_n = 0 asynchronously at hcnt = 700, vcnt = 491 -> hsync = 1, vsync = 1, counters = 0 before the next clk edge; normal counting resumes after release.
REQ-039 The bench SHALL cover CLK_DIV = 1: pix_tick constantly 1 and hcnt increments every clk; line period 800 clk; frame_start period 420000 clk.
